// File: rtl/medidor_potencia_ca_if.sv
// Measurement bus for the AC power meter: sample inputs in, window results out.
interface medidor_potencia_ca_if;
  logic        enable;
  logic        sample_valid;
  logic [31:0] tensao;
  logic [31:0] corrente;
  logic [63:0] potencia_media;
  logic [31:0] v_pico;
  logic [31:0] i_pico;
  logic [15:0] window_count;
  logic        result_valid;

  // Source side: drives samples, observes results.
  modport master (
    output enable, sample_valid, tensao, corrente,
    input  potencia_media, v_pico, i_pico, window_count, result_valid
  );

  // Meter side: consumes samples, produces results.
  modport slave (
    input  enable, sample_valid, tensao, corrente,
    output potencia_media, v_pico, i_pico, window_count, result_valid
  );
endinterface

// File: rtl/medidor_potencia_ca.sv
// Windowed AC power meter: multiplies voltage and current samples, averages
// the power over 2^WINDOW_LOG2 accepted samples and tracks peak |v| and |i|.
// Pipeline: product (stage 1) -> accumulate (stage 2) -> hold -> outputs,
// so the result for the window's last sample appears three edges later.
module medidor_potencia_ca #(
  parameter int WINDOW_LOG2 = 10
) (
  input logic                clk,
  input logic                rst,
  medidor_potencia_ca_if.slave bus
);

  localparam int ACC_W = 64 + WINDOW_LOG2;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic flush;

  // Stage 1: product and magnitudes
  logic               s1_valid;
  logic signed [63:0] s1_prod;
  logic [31:0]        s1_abs_v;
  logic [31:0]        s1_abs_i;

  // Stage 2: window accumulation
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_next;
  logic [WINDOW_LOG2-1:0]  sample_count;
  logic [31:0]             peak_v;
  logic [31:0]             peak_i;
  logic [31:0]             peak_v_next;
  logic [31:0]             peak_i_next;
  logic                    done_valid;
  logic [63:0]             done_mean;
  logic [31:0]             done_v;
  logic [31:0]             done_i;

  // Stage 3: hold register ahead of the outputs
  logic        hold_valid;
  logic [63:0] hold_mean;
  logic [31:0] hold_v;
  logic [31:0] hold_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state follows enable; leaving RUN discards the partial window
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.enable)  state_next = S_RUN;
      S_RUN:   if (!bus.enable) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = (state == S_RUN) && bus.enable && bus.sample_valid;
  assign flush  = (state_next == S_IDLE);

  // Stage 1: full-precision signed product and unsaturated magnitudes
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_abs_v <= '0;
      s1_abs_i <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod  <= 64'($signed(bus.tensao)) * 64'($signed(bus.corrente));
        s1_abs_v <= bus.tensao[31]   ? (~bus.tensao + 32'd1)   : bus.tensao;
        s1_abs_i <= bus.corrente[31] ? (~bus.corrente + 32'd1) : bus.corrente;
      end
    end
  end

  assign sum_next    = acc + $signed({{WINDOW_LOG2{s1_prod[63]}}, s1_prod});
  assign peak_v_next = (s1_abs_v > peak_v) ? s1_abs_v : peak_v;
  assign peak_i_next = (s1_abs_i > peak_i) ? s1_abs_i : peak_i;

  // Stage 2: accumulate; on the last sample latch the window and restart at 0.
  // The mean is the sum's upper 64 bits, i.e. an arithmetic shift (floor).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      acc          <= '0;
      sample_count <= '0;
      peak_v       <= '0;
      peak_i       <= '0;
      done_valid   <= 1'b0;
      done_mean    <= '0;
      done_v       <= '0;
      done_i       <= '0;
    end else begin
      done_valid <= 1'b0;
      if (s1_valid) begin
        if (&sample_count) begin
          done_valid   <= 1'b1;
          done_mean    <= sum_next[ACC_W-1:WINDOW_LOG2];
          done_v       <= peak_v_next;
          done_i       <= peak_i_next;
          acc          <= '0;
          sample_count <= '0;
          peak_v       <= '0;
          peak_i       <= '0;
        end else begin
          acc          <= sum_next;
          sample_count <= sample_count + 1'b1;
          peak_v       <= peak_v_next;
          peak_i       <= peak_i_next;
        end
      end
    end
  end

  // Stage 3: carry the finished window one more cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_valid <= 1'b0;
      hold_mean  <= '0;
      hold_v     <= '0;
      hold_i     <= '0;
    end else begin
      hold_valid <= done_valid;
      hold_mean  <= done_mean;
      hold_v     <= done_v;
      hold_i     <= done_i;
    end
  end

  // Outputs: update with a one-cycle pulse, otherwise hold until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.potencia_media <= '0;
      bus.v_pico         <= '0;
      bus.i_pico         <= '0;
      bus.window_count   <= '0;
      bus.result_valid   <= 1'b0;
    end else if (flush) begin
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= hold_valid;
      if (hold_valid) begin
        bus.potencia_media <= hold_mean;
        bus.v_pico         <= hold_v;
        bus.i_pico         <= hold_i;
        bus.window_count   <= bus.window_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_medidor_potencia_ca.sv
// Testbench for medidor_potencia_ca with a window of 4 samples.
module tb_medidor_potencia_ca;

  localparam int WL = 2;
  localparam int N  = 4;

  logic clk;
  logic rst;

  medidor_potencia_ca_if bus ();

  medidor_potencia_ca #(.WINDOW_LOG2(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] edge_no;
    logic [63:0] pm;
    logic [31:0] vp;
    logic [31:0] ip;
    logic [15:0] wc;
  } res_t;

  typedef struct packed {
    logic [31:0] due;
    logic [63:0] pm;
    logic [31:0] vp;
    logic [31:0] ip;
  } pend_t;

  res_t        exp_q[$];
  res_t        obs_q[$];
  pend_t       pend_q[$];
  longint      win_p[$];
  logic [31:0] win_v[$];
  logic [31:0] win_i[$];
  bit          m_run;
  logic [15:0] m_wc;
  int unsigned edge_no;
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every result pulse with the edge number that produced it
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1)
      obs_q.push_back('{edge_no, bus.potencia_media, bus.v_pico, bus.i_pico, bus.window_count});
  end

  function automatic logic [31:0] mag(input logic [31:0] x);
    logic signed [32:0] s;
    s = $signed({x[31], x});
    if (s < 0) s = -s;
    return s[31:0];
  endfunction

  // Reference model: list of accepted samples per window, results due 3 edges later
  task automatic model_edge(input bit r, input bit en, input bit sv,
                            input logic [31:0] v, input logic [31:0] i);
    logic signed [79:0] sum;
    logic signed [79:0] q;
    logic signed [79:0] nn;
    logic [31:0]        mv;
    logic [31:0]        mi;
    pend_t              p;
    if (r) begin
      pend_q.delete(); win_p.delete(); win_v.delete(); win_i.delete();
      m_run = 1'b0;
      m_wc  = 16'd0;
      return;
    end
    if (!en) begin
      pend_q.delete(); win_p.delete(); win_v.delete(); win_i.delete();
    end else begin
      while (pend_q.size() > 0 && pend_q[0].due == edge_no) begin
        p = pend_q.pop_front();
        m_wc = m_wc + 16'd1;
        exp_q.push_back('{p.due, p.pm, p.vp, p.ip, m_wc});
      end
    end
    if (m_run && en && sv) begin
      win_p.push_back(longint'($signed(v)) * longint'($signed(i)));
      win_v.push_back(v);
      win_i.push_back(i);
      if (win_p.size() == N) begin
        sum = 0; mv = 0; mi = 0; nn = 80'(N);
        for (int k = 0; k < N; k++) begin
          sum = sum + 80'(win_p[k]);
          if (mag(win_v[k]) > mv) mv = mag(win_v[k]);
          if (mag(win_i[k]) > mi) mi = mag(win_i[k]);
        end
        if (sum >= 0) q = sum / nn;
        else          q = -((-sum + nn - 1) / nn);
        pend_q.push_back('{edge_no + 3, q[63:0], mv, mi});
        win_p.delete(); win_v.delete(); win_i.delete();
      end
    end
    m_run = en;
  endtask

  // Drive one clock cycle of inputs and advance the model by one edge
  task automatic drive(input bit r, input bit en, input bit sv,
                       input logic [31:0] v, input logic [31:0] i);
    rst              = r;
    bus.enable       = en;
    bus.sample_valid = sv;
    bus.tensao       = v;
    bus.corrente     = i;
    @(posedge clk);
    edge_no++;
    model_edge(r, en, sv, v, i);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 2; k++)
      drive(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
    n_cmp++;
    if (bus.potencia_media !== 64'd0) begin
      n_fail++; $display("[TB] FAIL reset_pm: got %h, want 0", bus.potencia_media);
    end
    n_cmp++;
    if (bus.v_pico !== 32'd0 || bus.i_pico !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_peaks: got v=%h i=%h, want 0", bus.v_pico, bus.i_pico);
    end
    n_cmp++;
    if (bus.window_count !== 16'd0 || bus.result_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_wc_rv: got wc=%h rv=%b, want 0/0", bus.window_count, bus.result_valid);
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
    n_cmp++;
    if (obs_q.size() !== 0 || bus.window_count !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_quiet: got %0d pulses wc=%h, want 0 pulses wc=0", obs_q.size(), bus.window_count);
    end
  endtask

  task automatic test_basic;
    int unsigned t4;
    obs_q.delete(); exp_q.delete();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b1, 32'd100, 32'd200);
    t4 = edge_no;
    idle(6);
    n_cmp++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++; $display("[TB] FAIL basic_count: got %0d pulses (model %0d), want 1", obs_q.size(), exp_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("[TB] FAIL basic_model: got %h, want %h", obs_q[0], exp_q[0]);
      end
      n_cmp++;
      if (obs_q[0].edge_no !== t4 + 3 || obs_q[0].pm !== 64'd20000 || obs_q[0].vp !== 32'd100 ||
          obs_q[0].ip !== 32'd200 || obs_q[0].wc !== 16'd1) begin
        n_fail++; $display("[TB] FAIL basic_const: got %h, want edge %0d pm 20000 v 100 i 200 wc 1", obs_q[0], t4 + 3);
      end
    end
  endtask

  task automatic test_signed_gaps;
    logic [31:0] vs[4];
    logic [63:0] want[3];
    vs = '{32'd2, -32'sd4, 32'd6, 32'd8};
    want = '{64'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, vs[k], 32'd5);
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
    idle(6);
    n_cmp++;
    if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
      n_fail++; $display("[TB] FAIL signed_count: got %0d pulses (model %0d), want 3", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++; $display("[TB] FAIL signed_model[%0d]: got %h, want %h", k, obs_q[k], exp_q[k]);
        end
        n_cmp++;
        if (obs_q[k].pm !== want[k]) begin
          n_fail++; $display("[TB] FAIL signed_pm[%0d]: got %h, want %h", k, obs_q[k].pm, want[k]);
        end
      end
      n_cmp++;
      if (obs_q[0].vp !== 32'd8 || obs_q[0].ip !== 32'd5) begin
        n_fail++; $display("[TB] FAIL signed_peaks: got v=%0d i=%0d, want 8/5", obs_q[0].vp, obs_q[0].ip);
      end
    end
  endtask

  task automatic test_extremes;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
    idle(6);
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("[TB] FAIL extreme_count: got %0d pulses, want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0].pm !== 64'h4000_0000_0000_0000 || obs_q[0].vp !== 32'h8000_0000 ||
          obs_q[0].ip !== 32'h8000_0000) begin
        n_fail++; $display("[TB] FAIL extreme_vals: got pm=%h v=%h i=%h, want 4000000000000000/80000000/80000000",
                           obs_q[0].pm, obs_q[0].vp, obs_q[0].ip);
      end
      n_cmp++;
      if (exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
        n_fail++; $display("[TB] FAIL extreme_model: got %h, want model entry (%0d expected)", obs_q[0], exp_q.size());
      end
    end
  endtask

  task automatic test_abort;
    for (int pass = 0; pass < 2; pass++) begin
      obs_q.delete(); exp_q.delete();
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b1, 1'b1, 32'd10, 32'd10);
      if (pass == 0) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      else           drive(1'b1, 1'b1, 1'b1, 32'd10, 32'd10);
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b1, 32'd3, 32'd3);
      idle(6);
      n_cmp++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
        n_fail++; $display("[TB] FAIL abort%0d_count: got %0d pulses (model %0d), want 1", pass, obs_q.size(), exp_q.size());
      end else begin
        n_cmp++;
        if (obs_q[0] !== exp_q[0] || obs_q[0].pm !== 64'd9 || obs_q[0].vp !== 32'd3) begin
          n_fail++; $display("[TB] FAIL abort%0d_vals: got %h, want %h (pm 9 v 3)", pass, obs_q[0], exp_q[0]);
        end
        if (pass == 1) begin
          n_cmp++;
          if (obs_q[0].wc !== 16'd1) begin
            n_fail++; $display("[TB] FAIL abort_rst_wc: got %0d, want 1", obs_q[0].wc);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_q.delete(); exp_q.delete();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, 1'b1, 32'd7, -32'sd7);
    idle(6);
    n_cmp++;
    if (obs_q.size() !== 3) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d pulses, want 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_q[k].pm !== 64'hFFFF_FFFF_FFFF_FFCF || obs_q[k].wc !== 16'(k + 1)) begin
          n_fail++; $display("[TB] FAIL b2b_win[%0d]: got pm=%h wc=%0d, want ffffffffffffffcf/%0d", k, obs_q[k].pm, obs_q[k].wc, k + 1);
        end
        if (k > 0) begin
          n_cmp++;
          if (obs_q[k].edge_no - obs_q[k-1].edge_no !== 32'd4) begin
            n_fail++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d, want 4", k, obs_q[k].edge_no - obs_q[k-1].edge_no);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    bit          r;
    bit          en;
    bit          sv;
    logic [31:0] v;
    logic [31:0] i;
    obs_q.delete(); exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 29) != 0);
      sv = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      i  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      drive(r, en, sv, v, i);
    end
    idle(6);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("[TB] FAIL random_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL random[%0d]: got %h, want %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    edge_no = 0;
    m_run   = 1'b0;
    m_wc    = 16'd0;
    test_reset();
    test_basic();
    test_signed_gaps();
    test_extremes();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
